sample_accum: RTL and testbench

//  Paced accumulate-and-decimate stage sitting directly downstream of sample.
//  - Accepts one din item per strobe, i.e. once every PERIOD cycles.
//  - Sums NUM accepted items and emits the sum as a single dout item.
//  - Relies on sample's held, continuously valid output, so a read at any strobe sees the latest value.

---
 rtl/sample_accum_pkg.sv | 22 ++
 rtl/dti.sv | 12 +
 rtl/strobe_gen.sv | 25 ++
 rtl/sample_accum.sv | 65 ++++++
 tb/tb_sample_accum.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_accum_pkg.sv
// Shared helpers for the paced accumulate-and-decimate stage.
// Width derivation and sign/zero extension of incoming samples.
package sample_accum_pkg;

  localparam int MAX_W = 64;

  function automatic int accum_width(input int din_w, input int num);
    return din_w + $clog2(num);
  endfunction

  function automatic logic [MAX_W-1:0] ext(
    input logic [MAX_W-1:0] data,
    input int               din_w,
    input logic             signed_en
  );
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} << din_w;
    if (signed_en && data[din_w-1]) return data | mask;
    return data & ~mask;
  endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready data transfer interface.
// Producer holds valid/data until ready is seen.
interface dti #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer(output valid, output data, input ready);
  modport consumer(input valid, input data, output ready);
endinterface

// File: rtl/strobe_gen.sv
// Free-running modulo-PERIOD counter; strobe on the last count.
// Shared by paced stages that sample once every PERIOD cycles.
module strobe_gen #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] tcnt;

  assign strobe = tcnt == CW'(PERIOD - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (strobe) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + CW'(1);
    end
  end
endmodule

// File: rtl/sample_accum.sv
// Sums NUM strobed din samples and emits each sum on dout.
// Only a completing item waits on an occupied output.
module sample_accum
  import sample_accum_pkg::*;
#(
  parameter int DIN_W  = 16,
  parameter int NUM    = 4,
  parameter int PERIOD = 4,
  parameter int SIGNED = 0,
  parameter int DOUT_W = accum_width(DIN_W, NUM)
) (
  input logic  clk,
  input logic  rst,
  dti.consumer din,
  dti.producer dout
);
  localparam int SCW = (NUM > 1) ? $clog2(NUM) : 1;

  logic              strobe;
  logic              stall;
  logic              last;
  logic              take;
  logic [SCW-1:0]    scnt;
  logic [DOUT_W-1:0] acc;
  logic [DOUT_W-1:0] x;
  logic [DOUT_W-1:0] sum;

  strobe_gen #(
    .PERIOD(PERIOD)
  ) u_strobe (
    .clk,
    .rst,
    .strobe
  );

  assign last      = scnt == SCW'(NUM - 1);
  assign stall     = last && dout.valid && !dout.ready;
  assign din.ready = strobe && !stall;
  assign take      = din.valid && din.ready;
  assign x         = DOUT_W'(ext(MAX_W'(din.data), DIN_W, SIGNED != 0));
  assign sum       = acc + x;

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt       <= '0;
      acc        <= '0;
      dout.valid <= 1'b0;
      dout.data  <= '0;
    end else begin
      if (dout.valid && dout.ready) dout.valid <= 1'b0;
      // a completing item overrides the drain so back-to-back sums keep valid high
      if (take) begin
        if (last) begin
          dout.data  <= sum;
          dout.valid <= 1'b1;
          acc        <= '0;
          scnt       <= '0;
        end else begin
          acc  <= sum;
          scnt <= scnt + SCW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_sample_accum.sv
// Bench for sample_accum: directed scenarios plus randomized runs
// against a sum-of-accepted-items reference model.
module tb_sample_accum;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  dti #(.W(8))  i1 ();
  dti #(.W(10)) o1 ();
  dti #(.W(8))  i2 ();
  dti #(.W(10)) o2 ();
  dti #(.W(8))  i3 ();
  dti #(.W(9))  o3 ();
  dti #(.W(8))  i4 ();
  dti #(.W(9))  o4 ();
  dti #(.W(8))  i5 ();
  dti #(.W(8))  o5 ();

  sample_accum #(.DIN_W(8), .NUM(4), .PERIOD(4), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .din(i1), .dout(o1));
  sample_accum #(.DIN_W(8), .NUM(4), .PERIOD(1), .SIGNED(1)) u2 (
    .clk(clk), .rst(rst), .din(i2), .dout(o2));
  sample_accum #(.DIN_W(8), .NUM(2), .PERIOD(1), .SIGNED(0)) u3 (
    .clk(clk), .rst(rst), .din(i3), .dout(o3));
  sample_accum #(.DIN_W(8), .NUM(2), .PERIOD(4), .SIGNED(0)) u4 (
    .clk(clk), .rst(rst), .din(i4), .dout(o4));
  sample_accum #(.DIN_W(8), .NUM(1), .PERIOD(1), .SIGNED(0)) u5 (
    .clk(clk), .rst(rst), .din(i5), .dout(o5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    i1.valid = 0; i1.data = 0; o1.ready = 0;
    i2.valid = 0; i2.data = 0; o2.ready = 0;
    i3.valid = 0; i3.data = 0; o3.ready = 0;
    i4.valid = 0; i4.data = 0; o4.ready = 0;
    i5.valid = 0; i5.data = 0; o5.ready = 0;
  endtask

  // called at a negedge; returns at the negedge starting cycle 0
  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (o1.valid !== 1'b0 || o1.data !== 10'd0) begin
      errs++;
      $display("FAIL reset_u1 got=%0b/%0h exp=0/0", o1.valid, o1.data);
    end
    checks++;
    if (o2.valid !== 1'b0 || o3.valid !== 1'b0 ||
        o4.valid !== 1'b0 || o5.valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid got=%0b%0b%0b%0b exp=0000",
               o2.valid, o3.valid, o4.valid, o5.valid);
    end
    checks++;
    if (i1.ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready got=%0b exp=0", i1.ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic exp_rdy;
    logic exp_v;
    do_reset();
    i1.valid = 1; i1.data = 8'd10; o1.ready = 1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      #1;
      exp_rdy = (cyc % 4) == 3;
      exp_v   = (cyc >= 16) && (cyc % 16 == 0);
      checks++;
      if (i1.ready !== exp_rdy) begin
        errs++;
        $display("FAIL basic_ready cyc=%0d got=%0b exp=%0b", cyc, i1.ready, exp_rdy);
      end
      checks++;
      if (o1.valid !== exp_v || (exp_v && o1.data !== 10'd40)) begin
        errs++;
        $display("FAIL basic_dout cyc=%0d got=%0b/%0d exp=%0b/40",
                 cyc, o1.valid, o1.data, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_signed();
    logic [7:0] vals [8];
    int         s2;
    logic [9:0] exp2;
    logic       exp_v;
    vals[0] = 8'hFF; vals[1] = 8'hFE; vals[2] = 8'h03; vals[3] = 8'h80;
    for (int i = 4; i < 8; i++) vals[i] = 8'($urandom);
    s2 = 0;
    for (int i = 4; i < 8; i++) s2 += int'($signed(vals[i]));
    exp2 = 10'(s2);
    do_reset();
    o2.ready = 1;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      i2.valid = cyc < 8;
      i2.data  = (cyc < 8) ? vals[cyc] : 8'd0;
      #1;
      exp_v = (cyc == 4) || (cyc == 8);
      checks++;
      if (o2.valid !== exp_v) begin
        errs++;
        $display("FAIL signed_valid cyc=%0d got=%0b exp=%0b", cyc, o2.valid, exp_v);
      end
      if (cyc == 4) begin
        checks++;
        if (o2.data !== 10'h380) begin
          errs++;
          $display("FAIL signed_sum1 got=%0h exp=380", o2.data);
        end
      end
      if (cyc == 8) begin
        checks++;
        if (o2.data !== exp2) begin
          errs++;
          $display("FAIL signed_sum2 got=%0h exp=%0h", o2.data, exp2);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic exp_rdy;
    logic exp_v;
    do_reset();
    i3.valid = 1; i3.data = 8'd5;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      o3.ready = cyc >= 10;
      #1;
      exp_rdy = !(cyc >= 3 && cyc <= 9);
      exp_v   = cyc >= 2 && cyc <= 11;
      checks++;
      if (i3.ready !== exp_rdy) begin
        errs++;
        $display("FAIL bp_ready cyc=%0d got=%0b exp=%0b", cyc, i3.ready, exp_rdy);
      end
      checks++;
      if (o3.valid !== exp_v || (exp_v && o3.data !== 9'd10)) begin
        errs++;
        $display("FAIL bp_dout cyc=%0d got=%0b/%0d exp=%0b/10",
                 cyc, o3.valid, o3.data, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_missed_strobe();
    logic exp_v;
    do_reset();
    o4.ready = 1;
    for (int cyc = 0; cyc <= 13; cyc++) begin
      i4.valid = cyc != 7;
      i4.data  = (cyc < 4) ? 8'd11 : (cyc < 8) ? 8'd99 : 8'd22;
      #1;
      exp_v = cyc == 12;
      checks++;
      if (o4.valid !== exp_v || (exp_v && o4.data !== 9'd33)) begin
        errs++;
        $display("FAIL miss_dout cyc=%0d got=%0b/%0d exp=%0b/33",
                 cyc, o4.valid, o4.data, exp_v);
      end
      if (cyc == 7) begin
        checks++;
        if (i4.ready !== 1'b1) begin
          errs++;
          $display("FAIL miss_ready cyc=7 got=%0b exp=1", i4.ready);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    logic exp_v;
    logic exp_rdy;
    do_reset();
    i1.valid = 1; i1.data = 8'd7; o1.ready = 1;
    for (int cyc = 0; cyc < 12; cyc++) @(negedge clk);
    do_reset();
    #1;
    checks++;
    if (o1.valid !== 1'b0) begin
      errs++;
      $display("FAIL mrst_partial_valid got=%0b exp=0", o1.valid);
    end
    @(negedge clk);
    i1.valid = 1; i1.data = 8'd1; o1.ready = 1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      #1;
      exp_rdy = (cyc % 4) == 3;
      exp_v   = cyc == 16;
      checks++;
      if (i1.ready !== exp_rdy) begin
        errs++;
        $display("FAIL mrst_ready cyc=%0d got=%0b exp=%0b", cyc, i1.ready, exp_rdy);
      end
      checks++;
      if (o1.valid !== exp_v || (exp_v && o1.data !== 10'd4)) begin
        errs++;
        $display("FAIL mrst_dout cyc=%0d got=%0b/%0d exp=%0b/4",
                 cyc, o1.valid, o1.data, exp_v);
      end
      @(negedge clk);
    end
    // second case: reset while a finished sum is waiting
    do_reset();
    i1.valid = 1; i1.data = 8'd2; o1.ready = 0;
    for (int cyc = 0; cyc < 16; cyc++) @(negedge clk);
    #1;
    checks++;
    if (o1.valid !== 1'b1 || o1.data !== 10'd8) begin
      errs++;
      $display("FAIL mrst_held got=%0b/%0d exp=1/8", o1.valid, o1.data);
    end
    @(negedge clk);
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      o1.ready = 1;
      #1;
      checks++;
      if (o1.valid !== 1'b0) begin
        errs++;
        $display("FAIL mrst_drop cyc=%0d got=%0b exp=0", cyc, o1.valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_model();
    int         t;
    int         items[$];
    int         acc;
    logic       mv;
    logic [9:0] md;
    logic       exp_rdy;
    logic       take;
    do_reset();
    t = 0; mv = 0; md = 0;
    items.delete();
    for (int n = 0; n < 300; n++) begin
      i1.valid = ($urandom % 4) != 0;
      i1.data  = 8'($urandom);
      o1.ready = ($urandom % 3) != 0;
      #1;
      exp_rdy = ((t % 4) == 3) &&
                !(items.size() == 3 && mv && !o1.ready);
      checks++;
      if (i1.ready !== exp_rdy) begin
        errs++;
        $display("FAIL rnd_ready t=%0d got=%0b exp=%0b", t, i1.ready, exp_rdy);
      end
      checks++;
      if (o1.valid !== mv || (mv && o1.data !== md)) begin
        errs++;
        $display("FAIL rnd_dout t=%0d got=%0b/%0d exp=%0b/%0d",
                 t, o1.valid, o1.data, mv, md);
      end
      take = i1.valid && exp_rdy;
      if (mv && o1.ready) mv = 0;
      if (take) begin
        items.push_back(int'(i1.data));
        if (items.size() == 4) begin
          acc = 0;
          foreach (items[k]) acc += items[k];
          md = 10'(acc);
          mv = 1;
          items.delete();
        end
      end
      t++;
      @(negedge clk);
    end
  endtask

  task automatic test_num1_scoreboard();
    logic [7:0] sb[$];
    logic [7:0] exp;
    do_reset();
    sb.delete();
    for (int n = 0; n < 400; n++) begin
      i5.valid = ($urandom % 3) != 0;
      i5.data  = 8'($urandom);
      o5.ready = ($urandom % 2) != 0 || n >= 380;
      if (n >= 380) i5.valid = 0;
      #1;
      if (o5.valid && o5.ready) begin
        checks++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL n1_dup n=%0d got=%0d exp=none", n, o5.data);
        end else begin
          exp = sb.pop_front();
          if (o5.data !== exp) begin
            errs++;
            $display("FAIL n1_data n=%0d got=%0d exp=%0d", n, o5.data, exp);
          end
        end
      end
      if (i5.valid && i5.ready) sb.push_back(i5.data);
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0 || o5.valid !== 1'b0) begin
      errs++;
      $display("FAIL n1_loss got=%0d/%0b exp=0/0", sb.size(), o5.valid);
    end
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_missed_strobe();
    test_mid_reset();
    test_random_model();
    test_num1_scoreboard();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
